// File: rtl/glb_sram_bridge_if.sv
// GLB-side request/response bundle between the accelerator top (master)
// and the SRAM bridge (slave).
interface glb_sram_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  glb_read_ready;
  logic [ADDR_WIDTH-1:0] glb_read_addr;
  logic                  rd_req_ready;
  logic                  glb_read_valid;
  logic [DATA_WIDTH-1:0] glb_read_data;
  logic                  rd_resp_ready;
  logic                  glb_write_valid;
  logic [ADDR_WIDTH-1:0] glb_write_addr;
  logic [DATA_WIDTH-1:0] glb_write_data;
  logic [DATA_WIDTH-1:0] wr_bweb;
  logic                  glb_write_ready;

  modport master (
    output glb_read_ready, glb_read_addr, rd_resp_ready,
           glb_write_valid, glb_write_addr, glb_write_data, wr_bweb,
    input  rd_req_ready, glb_read_valid, glb_read_data, glb_write_ready
  );

  modport slave (
    input  glb_read_ready, glb_read_addr, rd_resp_ready,
           glb_write_valid, glb_write_addr, glb_write_data, wr_bweb,
    output rd_req_ready, glb_read_valid, glb_read_data, glb_write_ready
  );
endinterface

// File: rtl/glb_sram_bridge.sv
// Byte-addressed GLB port to word-addressed single-cycle SRAM macro, with a
// small response FIFO for consumer stalls and same-edge write-to-read forwarding.
module glb_sram_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16384,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  glb_sram_bridge_if.slave           glb,
  output logic                       sram_RE,
  output logic [$clog2(DEPTH)-1:0]   sram_R_ADDR,
  output logic                       sram_WEB,
  output logic [DATA_WIDTH-1:0]      sram_BWEB,
  output logic [$clog2(DEPTH)-1:0]   sram_W_ADDR,
  output logic [DATA_WIDTH-1:0]      sram_D_IN,
  input  logic [DATA_WIDTH-1:0]      sram_D_OUT,
  output logic                       err_misaligned,
  output logic                       err_range,
  output logic                       bridge_idle
);

  localparam int WA_W  = $clog2(DEPTH);
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH:0] BYTE_LIMIT = (ADDR_WIDTH+1)'(DEPTH * 4);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < BYTE_LIMIT;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fwd_merge(
    input logic [DATA_WIDTH-1:0] rdata,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] mask
  );
    return (rdata & mask) | (wdata & ~mask);
  endfunction

  logic                  alive_q, alive_d;
  logic                  inflight_q, inflight_d;
  logic                  rd_zero_q, rd_zero_d;
  logic                  fwd_hit_q, fwd_hit_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [DATA_WIDTH-1:0] fwd_mask_q, fwd_mask_d;
  logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic                  err_mis_q, err_mis_d;
  logic                  err_rng_q, err_rng_d;
  logic [DATA_WIDTH-1:0] fifo_mem_q [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_mem_d [RSP_DEPTH];

  logic                  req_ok, rd_acc, rd_ok, wr_acc, wr_ok, collide;
  logic                  fifo_empty, push, pop;
  logic [DATA_WIDTH-1:0] cur_data;

  // Request stage: accept decision and SRAM drive, all same-cycle
  always_comb begin
    req_ok  = alive_q & ((fifo_cnt_q + CNT_W'(inflight_q)) < CNT_W'(RSP_DEPTH));
    rd_acc  = glb.glb_read_ready & req_ok;
    rd_ok   = rd_acc & in_range(glb.glb_read_addr);
    wr_acc  = glb.glb_write_valid & alive_q;
    wr_ok   = wr_acc & in_range(glb.glb_write_addr);
    collide = rd_ok & wr_ok &
              (glb.glb_read_addr[WA_W+1:2] == glb.glb_write_addr[WA_W+1:2]);

    sram_RE     = rd_ok;
    sram_R_ADDR = rd_acc ? glb.glb_read_addr[WA_W+1:2] : '0;
    sram_WEB    = ~wr_ok;
    sram_BWEB   = wr_ok ? glb.wr_bweb : '1;
    sram_W_ADDR = wr_ok ? glb.glb_write_addr[WA_W+1:2] : '0;
    sram_D_IN   = wr_ok ? glb.glb_write_data : '0;
  end

  // Response stage: SRAM data (zeroed or forwarded) vs. buffered head
  always_comb begin
    if (rd_zero_q)      cur_data = '0;
    else if (fwd_hit_q) cur_data = fwd_merge(sram_D_OUT, fwd_data_q, fwd_mask_q);
    else                cur_data = sram_D_OUT;

    fifo_empty = (fifo_cnt_q == '0);
    push       = inflight_q & ~(fifo_empty & glb.rd_resp_ready);
    pop        = glb.rd_resp_ready & ~fifo_empty;

    alive_d    = 1'b1;
    inflight_d = rd_acc;
    rd_zero_d  = rd_acc & ~rd_ok;
    fwd_hit_d  = collide;
    fwd_data_d = collide ? glb.glb_write_data : fwd_data_q;
    fwd_mask_d = collide ? glb.wr_bweb : fwd_mask_q;
    fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    err_mis_d  = err_mis_q | (rd_acc & (|glb.glb_read_addr[1:0]))
                           | (wr_acc & (|glb.glb_write_addr[1:0]));
    err_rng_d  = err_rng_q | (rd_acc & ~rd_ok) | (wr_acc & ~wr_ok);

    fifo_mem_d = fifo_mem_q;
    if (push) fifo_mem_d[wr_ptr_q] = cur_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alive_q    <= 1'b0;
      inflight_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_mask_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_mis_q  <= 1'b0;
      err_rng_q  <= 1'b0;
    end else begin
      alive_q    <= alive_d;
      inflight_q <= inflight_d;
      rd_zero_q  <= rd_zero_d;
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      fwd_mask_q <= fwd_mask_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      err_mis_q  <= err_mis_d;
      err_rng_q  <= err_rng_d;
    end
  end

  // Storage is qualified by the count, so it needs no reset
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  assign glb.rd_req_ready    = req_ok;
  assign glb.glb_write_ready = alive_q;
  assign glb.glb_read_valid  = inflight_q | ~fifo_empty;
  assign glb.glb_read_data   = ~fifo_empty ? fifo_mem_q[rd_ptr_q]
                                           : (inflight_q ? cur_data : '0);
  assign err_misaligned      = err_mis_q;
  assign err_range           = err_rng_q;
  assign bridge_idle         = ~inflight_q & fifo_empty;

endmodule

// File: tb/tb_glb_sram_bridge.sv
// Directed bench for glb_sram_bridge with a behavioural 1-cycle SRAM macro.
module tb_glb_sram_bridge;

  logic        clk;
  logic        rst;
  logic        sram_RE;
  logic [13:0] sram_R_ADDR;
  logic        sram_WEB;
  logic [31:0] sram_BWEB;
  logic [13:0] sram_W_ADDR;
  logic [31:0] sram_D_IN;
  logic [31:0] sram_D_OUT;
  logic        err_misaligned;
  logic        err_range;
  logic        bridge_idle;

  logic [31:0] mem [16384];
  logic        pre_we;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;

  int n_checks = 0;
  int n_fail   = 0;

  glb_sram_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) glb_if ();

  glb_sram_bridge dut (
    .clk            (clk),
    .rst            (rst),
    .glb            (glb_if),
    .sram_RE        (sram_RE),
    .sram_R_ADDR    (sram_R_ADDR),
    .sram_WEB       (sram_WEB),
    .sram_BWEB      (sram_BWEB),
    .sram_W_ADDR    (sram_W_ADDR),
    .sram_D_IN      (sram_D_IN),
    .sram_D_OUT     (sram_D_OUT),
    .err_misaligned (err_misaligned),
    .err_range      (err_range),
    .bridge_idle    (bridge_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: read returns old contents on a same-edge write
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (!sram_WEB)
      mem[sram_W_ADDR] <= (mem[sram_W_ADDR] & sram_BWEB) | (sram_D_IN & ~sram_BWEB);
    if (sram_RE) sram_D_OUT <= mem[sram_R_ADDR];
  end

  task automatic idle_inputs();
    glb_if.glb_read_ready  = 1'b0;
    glb_if.glb_read_addr   = 32'h0;
    glb_if.rd_resp_ready   = 1'b1;
    glb_if.glb_write_valid = 1'b0;
    glb_if.glb_write_addr  = 32'h0;
    glb_if.glb_write_data  = 32'h0;
    glb_if.wr_bweb         = 32'hFFFF_FFFF;
  endtask

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (glb_if.glb_read_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", glb_if.glb_read_valid); end
    n_checks++; if (glb_if.glb_read_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", glb_if.glb_read_data); end
    n_checks++; if (glb_if.rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", glb_if.rd_req_ready); end
    n_checks++; if (glb_if.glb_write_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 0", glb_if.glb_write_ready); end
    n_checks++; if (bridge_idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %b want 1", bridge_idle); end
    n_checks++; if (sram_RE !== 1'b0) begin n_fail++; $display("FAIL rst_re: got %b want 0", sram_RE); end
    n_checks++; if (sram_WEB !== 1'b1) begin n_fail++; $display("FAIL rst_web: got %b want 1", sram_WEB); end
    n_checks++; if (sram_BWEB !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rst_bweb: got %h want ffffffff", sram_BWEB); end
    n_checks++; if (sram_W_ADDR !== 14'h0 || sram_D_IN !== 32'h0 || sram_R_ADDR !== 14'h0) begin n_fail++; $display("FAIL rst_addr: got w=%h d=%h r=%h want 0", sram_W_ADDR, sram_D_IN, sram_R_ADDR); end
    n_checks++; if (err_misaligned !== 1'b0 || err_range !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b%b want 00", err_misaligned, err_range); end
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (glb_if.rd_req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 1", glb_if.rd_req_ready); end
    n_checks++; if (glb_if.glb_write_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_wr_ready: got %b want 1", glb_if.glb_write_ready); end
  endtask

  task automatic test_single_read();
    preload(14'd256, 32'hDEAD_BEEF);
    @(negedge clk);
    glb_if.glb_read_ready = 1'b1; glb_if.glb_read_addr = 32'h400; glb_if.rd_resp_ready = 1'b1;
    #1;
    n_checks++; if (sram_RE !== 1'b1 || sram_R_ADDR !== 14'd256) begin n_fail++; $display("FAIL single_issue: got re=%b addr=%0d want re=1 addr=256", sram_RE, sram_R_ADDR); end
    n_checks++; if (glb_if.glb_read_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", glb_if.glb_read_valid); end
    @(negedge clk);
    glb_if.glb_read_ready = 1'b0;
    n_checks++; if (glb_if.glb_read_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", glb_if.glb_read_valid); end
    n_checks++; if (glb_if.glb_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", glb_if.glb_read_data); end
    n_checks++; if (bridge_idle !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b want 0", bridge_idle); end
    @(negedge clk);
    n_checks++; if (glb_if.glb_read_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b want 0", glb_if.glb_read_valid); end
    n_checks++; if (bridge_idle !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", bridge_idle); end
  endtask

  task automatic test_back_to_back();
    int req = 0;
    int rsp = 0;
    for (int i = 0; i < 4; i++) preload(14'(i), 32'hC0DE_0000 | 32'(i));
    for (int k = 0; k < 24 && rsp < 4; k++) begin
      @(negedge clk);
      glb_if.rd_resp_ready  = (k >= 4);
      glb_if.glb_read_ready = (req < 4);
      glb_if.glb_read_addr  = 32'(req) << 2;
      #1;
      if (k == 2 || k == 3) begin
        n_checks++; if (glb_if.rd_req_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_req_ready_k%0d: got %b want 0", k, glb_if.rd_req_ready); end
        n_checks++; if (req != 2) begin n_fail++; $display("FAIL b2b_accepts_k%0d: got %0d want 2", k, req); end
      end
      if (glb_if.glb_read_ready && !glb_if.rd_req_ready) begin
        n_checks++; if (sram_RE !== 1'b0) begin n_fail++; $display("FAIL b2b_re_blocked_k%0d: got %b want 0", k, sram_RE); end
      end
      if (glb_if.glb_read_valid && glb_if.rd_resp_ready) begin
        n_checks++; if (glb_if.glb_read_data !== (32'hC0DE_0000 | 32'(rsp))) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", rsp, glb_if.glb_read_data, 32'hC0DE_0000 | 32'(rsp)); end
        rsp++;
      end
      if (glb_if.glb_read_ready && glb_if.rd_req_ready) req++;
    end
    n_checks++; if (rsp != 4) begin n_fail++; $display("FAIL b2b_rsp_count: got %0d want 4", rsp); end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (glb_if.glb_read_valid !== 1'b0 || bridge_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got valid=%b idle=%b want 0/1", glb_if.glb_read_valid, bridge_idle); end
  endtask

  task automatic test_collision();
    preload(14'd500, 32'hAAAA_BBBB);
    @(negedge clk);
    glb_if.glb_read_ready  = 1'b1; glb_if.glb_read_addr = 32'd2000; glb_if.rd_resp_ready = 1'b1;
    glb_if.glb_write_valid = 1'b1; glb_if.glb_write_addr = 32'd2000;
    glb_if.glb_write_data  = 32'h1122_3344; glb_if.wr_bweb = 32'hFFFF_0000;
    #1;
    n_checks++; if (sram_WEB !== 1'b0 || sram_W_ADDR !== 14'd500) begin n_fail++; $display("FAIL col_write: got web=%b addr=%0d want 0/500", sram_WEB, sram_W_ADDR); end
    n_checks++; if (sram_BWEB !== 32'hFFFF_0000 || sram_D_IN !== 32'h1122_3344) begin n_fail++; $display("FAIL col_wdata: got bweb=%h d=%h want ffff0000/11223344", sram_BWEB, sram_D_IN); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (glb_if.glb_read_valid !== 1'b1 || glb_if.glb_read_data !== 32'hAAAA_3344) begin n_fail++; $display("FAIL col_fwd: got v=%b %h want 1 aaaa3344", glb_if.glb_read_valid, glb_if.glb_read_data); end
    n_checks++; if (mem[500] !== 32'hAAAA_3344) begin n_fail++; $display("FAIL col_sram: got %h want aaaa3344", mem[500]); end
    @(negedge clk);
    glb_if.glb_read_ready  = 1'b1; glb_if.glb_read_addr = 32'd2000;
    glb_if.glb_write_valid = 1'b1; glb_if.glb_write_addr = 32'd2004;
    glb_if.glb_write_data  = 32'hFFFF_FFFF; glb_if.wr_bweb = 32'h0;
    @(negedge clk);
    idle_inputs();
    n_checks++; if (glb_if.glb_read_data !== 32'hAAAA_3344) begin n_fail++; $display("FAIL col_no_fwd: got %h want aaaa3344", glb_if.glb_read_data); end
    n_checks++; if (err_misaligned !== 1'b0 || err_range !== 1'b0) begin n_fail++; $display("FAIL col_err: got %b%b want 00", err_misaligned, err_range); end
  endtask

  task automatic test_errors();
    @(negedge clk);
    glb_if.glb_write_valid = 1'b1; glb_if.glb_write_addr = 32'h3A9A;
    glb_if.glb_write_data  = 32'h5A5A_5A5A; glb_if.wr_bweb = 32'h0;
    #1;
    n_checks++; if (sram_WEB !== 1'b0 || sram_W_ADDR !== 14'd3750) begin n_fail++; $display("FAIL mis_write: got web=%b addr=%0d want 0/3750", sram_WEB, sram_W_ADDR); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (err_misaligned !== 1'b1 || err_range !== 1'b0) begin n_fail++; $display("FAIL mis_flags: got mis=%b rng=%b want 1/0", err_misaligned, err_range); end
    n_checks++; if (mem[3750] !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL mis_sram: got %h want 5a5a5a5a", mem[3750]); end
    @(negedge clk);
    glb_if.glb_read_ready = 1'b1; glb_if.glb_read_addr = 32'h10001;
    #1;
    n_checks++; if (sram_RE !== 1'b0) begin n_fail++; $display("FAIL oor_re: got %b want 0", sram_RE); end
    @(negedge clk);
    idle_inputs();
    n_checks++; if (glb_if.glb_read_valid !== 1'b1 || glb_if.glb_read_data !== 32'h0) begin n_fail++; $display("FAIL oor_rsp: got v=%b %h want 1 0", glb_if.glb_read_valid, glb_if.glb_read_data); end
    n_checks++; if (err_range !== 1'b1 || err_misaligned !== 1'b1) begin n_fail++; $display("FAIL oor_flags: got rng=%b mis=%b want 1/1", err_range, err_misaligned); end
    @(negedge clk);
    glb_if.glb_write_valid = 1'b1; glb_if.glb_write_addr = 32'h10000; glb_if.wr_bweb = 32'h0;
    #1;
    n_checks++; if (sram_WEB !== 1'b1 || glb_if.glb_write_ready !== 1'b1) begin n_fail++; $display("FAIL oor_write: got web=%b rdy=%b want 1/1", sram_WEB, glb_if.glb_write_ready); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    glb_if.rd_resp_ready = 1'b0;
    glb_if.glb_read_ready = 1'b1; glb_if.glb_read_addr = 32'h0;
    @(negedge clk);
    glb_if.glb_read_addr = 32'h4;
    @(negedge clk);
    glb_if.glb_read_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (glb_if.glb_read_valid !== 1'b1 || bridge_idle !== 1'b0) begin n_fail++; $display("FAIL mid_buffered: got v=%b idle=%b want 1/0", glb_if.glb_read_valid, bridge_idle); end
    #2;
    rst = 1'b0;
    glb_if.glb_write_valid = 1'b1; glb_if.glb_write_addr = 32'h8; glb_if.wr_bweb = 32'h0;
    glb_if.glb_read_ready = 1'b1;
    #1;
    n_checks++; if (glb_if.glb_read_valid !== 1'b0 || glb_if.glb_read_data !== 32'h0) begin n_fail++; $display("FAIL mid_valid: got v=%b %h want 0 0", glb_if.glb_read_valid, glb_if.glb_read_data); end
    n_checks++; if (sram_WEB !== 1'b1 || sram_BWEB !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mid_sram: got web=%b bweb=%h want 1 ffffffff", sram_WEB, sram_BWEB); end
    n_checks++; if (bridge_idle !== 1'b1 || sram_RE !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got idle=%b re=%b want 1/0", bridge_idle, sram_RE); end
    n_checks++; if (err_misaligned !== 1'b0 || err_range !== 1'b0) begin n_fail++; $display("FAIL mid_err: got %b%b want 00", err_misaligned, err_range); end
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    glb_if.glb_read_ready = 1'b1; glb_if.glb_read_addr = 32'h400;
    @(negedge clk);
    glb_if.glb_read_ready = 1'b0;
    n_checks++; if (glb_if.glb_read_valid !== 1'b1 || glb_if.glb_read_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL mid_new_read: got v=%b %h want 1 deadbeef", glb_if.glb_read_valid, glb_if.glb_read_data); end
    @(negedge clk);
    n_checks++; if (glb_if.glb_read_valid !== 1'b0 || bridge_idle !== 1'b1) begin n_fail++; $display("FAIL mid_no_stale: got v=%b idle=%b want 0/1", glb_if.glb_read_valid, bridge_idle); end
  endtask

  initial begin
    rst = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    idle_inputs();
    glb_if.glb_write_valid = 1'b1;
    glb_if.wr_bweb         = 32'h0;
    glb_if.glb_read_ready  = 1'b1;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_collision();
    test_errors();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
